// File: rtl/ccip_tag_tracker_pkg.sv
// Shared types and default widths for the CCI-P channel-0 read-tag tracker.
package ccip_tag_tracker_pkg;

   localparam int unsigned MdataWidth       = 16;
   localparam int unsigned DefTagWidth      = 6;
   localparam int unsigned DefTsWidth       = 16;
   localparam int unsigned DefTimeoutCycles = 4096;

   typedef enum logic [1:0] {
      TagFree     = 2'd0,
      TagPending  = 2'd1,
      TagTimedOut = 2'd2
   } tag_state_e;

   // Issue timestamps live in a separate array because their width is a module parameter.
   typedef struct packed {
      tag_state_e state;
      logic [1:0] remaining;
   } tag_entry_t;

   function automatic logic is_live(tag_state_e st);
      return st != TagFree;
   endfunction

endpackage

// File: rtl/ccip_c0_tag_tracker_if.sv
// C0 request/response sniff bus and tracker error reporting bundle.
interface ccip_c0_tag_tracker_if
   import ccip_tag_tracker_pkg::*;
#(
   parameter int unsigned TAG_WIDTH = DefTagWidth
) ();

   logic                  c0tx_valid;
   logic [MdataWidth-1:0] c0tx_mdata;
   logic [1:0]            c0tx_cl_len;
   logic                  c0rx_rdvalid;
   logic [MdataWidth-1:0] c0rx_mdata;

   logic                 err_dup;
   logic [TAG_WIDTH-1:0] err_dup_tag;
   logic                 err_unexp;
   logic [TAG_WIDTH-1:0] err_unexp_tag;
   logic                 err_timeout;
   logic [TAG_WIDTH-1:0] err_timeout_tag;
   logic [TAG_WIDTH:0]   outstanding_cnt;

   modport master (
      output c0tx_valid, c0tx_mdata, c0tx_cl_len, c0rx_rdvalid, c0rx_mdata,
      input  err_dup, err_dup_tag, err_unexp, err_unexp_tag,
      input  err_timeout, err_timeout_tag, outstanding_cnt
   );

   modport slave (
      input  c0tx_valid, c0tx_mdata, c0tx_cl_len, c0rx_rdvalid, c0rx_mdata,
      output err_dup, err_dup_tag, err_unexp, err_unexp_tag,
      output err_timeout, err_timeout_tag, outstanding_cnt
   );

endinterface

// File: rtl/ccip_tag_timeout_scanner.sv
// Round-robin age scanner: checks one table entry per cycle and flags requests that aged out.
module ccip_tag_timeout_scanner
   import ccip_tag_tracker_pkg::*;
#(
   parameter int unsigned TAG_WIDTH      = DefTagWidth,
   parameter int unsigned TS_WIDTH       = DefTsWidth,
   parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
   input  logic                 clk,
   input  logic                 SoftReset,
   input  logic [TS_WIDTH-1:0]  now,
   input  tag_state_e           scan_state,
   input  logic [TS_WIDTH-1:0]  scan_ts,
   input  logic                 scan_hold,
   output logic [TAG_WIDTH-1:0] scan_idx,
   output logic                 mark_timed_out,
   output logic                 err_timeout,
   output logic [TAG_WIDTH-1:0] err_timeout_tag
);

   logic [TAG_WIDTH-1:0] idx_q;
   logic                 err_q;
   logic [TAG_WIDTH-1:0] err_tag_q;
   logic [TS_WIDTH-1:0]  age;

   // Modular subtraction keeps the age correct across timestamp wrap.
   assign age      = now - scan_ts;
   assign scan_idx = idx_q;

   always_comb begin
      mark_timed_out = (scan_state == TagPending) && (age >= TS_WIDTH'(TIMEOUT_CYCLES))
                       && !scan_hold;
   end

   always_ff @(posedge clk) begin
      if (SoftReset) begin
         idx_q     <= '0;
         err_q     <= 1'b0;
         err_tag_q <= '0;
      end else begin
         idx_q     <= idx_q + TAG_WIDTH'(1);
         err_q     <= mark_timed_out;
         err_tag_q <= mark_timed_out ? idx_q : '0;
      end
   end

   assign err_timeout     = err_q;
   assign err_timeout_tag = err_tag_q;

endmodule

// File: rtl/ccip_c0_tag_tracker.sv
// Passive CCI-P C0 read tracker: tags outstanding reads and pulses dup/unexpected/timeout errors.
module ccip_c0_tag_tracker
   import ccip_tag_tracker_pkg::*;
#(
   parameter int unsigned TAG_WIDTH      = DefTagWidth,
   parameter int unsigned TS_WIDTH       = DefTsWidth,
   parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
   input  logic                   clk,
   input  logic                   SoftReset,
   ccip_c0_tag_tracker_if.slave   bus
);

   localparam int unsigned Depth    = 2 ** TAG_WIDTH;
   localparam int unsigned CntWidth = TAG_WIDTH + 1;

   if (TIMEOUT_CYCLES >= 2 ** (TS_WIDTH - 1)) begin : gen_bad_timeout
      $error("TIMEOUT_CYCLES must be below 2**(TS_WIDTH-1)");
   end

   tag_entry_t          table_q [Depth];
   logic [TS_WIDTH-1:0] ts_q    [Depth];
   logic [TS_WIDTH-1:0] now_q;
   logic [CntWidth-1:0] cnt_q, cnt_d;

   logic                 err_dup_q, err_unexp_q;
   logic [TAG_WIDTH-1:0] err_dup_tag_q, err_unexp_tag_q;

   logic [TAG_WIDTH-1:0] tx_tag, rx_tag, scan_idx;
   tag_entry_t           rx_entry;
   tag_state_e           tx_pre_state, scan_state;
   logic                 rsp_unexp, rsp_free, rsp_dec, req_alloc, req_dup;
   logic                 scan_hold, mark_timed_out;
   logic                 err_timeout;
   logic [TAG_WIDTH-1:0] err_timeout_tag;

   logic unused_mdata;
   assign unused_mdata = ^{bus.c0tx_mdata[MdataWidth-1:TAG_WIDTH],
                           bus.c0rx_mdata[MdataWidth-1:TAG_WIDTH]};

   assign tx_tag     = bus.c0tx_mdata[TAG_WIDTH-1:0];
   assign rx_tag     = bus.c0rx_mdata[TAG_WIDTH-1:0];
   assign scan_state = table_q[scan_idx].state;

   always_comb begin
      rx_entry  = table_q[rx_tag];
      rsp_unexp = bus.c0rx_rdvalid && !is_live(rx_entry.state);
      rsp_free  = bus.c0rx_rdvalid && is_live(rx_entry.state) && (rx_entry.remaining == 2'd0);
      rsp_dec   = bus.c0rx_rdvalid && is_live(rx_entry.state) && (rx_entry.remaining != 2'd0);

      // The request sees the table as the same-cycle response leaves it.
      tx_pre_state = table_q[tx_tag].state;
      if (rsp_free && (rx_tag == tx_tag)) begin
         tx_pre_state = TagFree;
      end
      req_dup   = bus.c0tx_valid && is_live(tx_pre_state);
      req_alloc = bus.c0tx_valid && !is_live(tx_pre_state);

      scan_hold = (bus.c0rx_rdvalid && (rx_tag == scan_idx)) ||
                  (bus.c0tx_valid && (tx_tag == scan_idx));

      cnt_d = cnt_q + CntWidth'(req_alloc) - CntWidth'(rsp_free);
   end

   always_ff @(posedge clk) begin
      if (SoftReset) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            table_q[i] <= '0;
         end
         now_q           <= '0;
         cnt_q           <= '0;
         err_dup_q       <= 1'b0;
         err_dup_tag_q   <= '0;
         err_unexp_q     <= 1'b0;
         err_unexp_tag_q <= '0;
      end else begin
         now_q <= now_q + TS_WIDTH'(1);
         cnt_q <= cnt_d;
         // Later assignments win: scanner < response < request.
         if (mark_timed_out) begin
            table_q[scan_idx].state <= TagTimedOut;
         end
         if (rsp_free) begin
            table_q[rx_tag].state <= TagFree;
         end
         if (rsp_dec) begin
            table_q[rx_tag].remaining <= rx_entry.remaining - 2'd1;
         end
         if (bus.c0tx_valid) begin
            table_q[tx_tag] <= '{state: TagPending, remaining: bus.c0tx_cl_len};
         end
         err_dup_q       <= req_dup;
         err_dup_tag_q   <= req_dup ? tx_tag : '0;
         err_unexp_q     <= rsp_unexp;
         err_unexp_tag_q <= rsp_unexp ? rx_tag : '0;
      end
   end

   // Timestamps are only meaningful for live entries, so they need no reset.
   always_ff @(posedge clk) begin
      if (!SoftReset && bus.c0tx_valid) begin
         ts_q[tx_tag] <= now_q;
      end
   end

   ccip_tag_timeout_scanner #(
      .TAG_WIDTH      (TAG_WIDTH),
      .TS_WIDTH       (TS_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_scanner (
      .clk             (clk),
      .SoftReset       (SoftReset),
      .now             (now_q),
      .scan_state      (scan_state),
      .scan_ts         (ts_q[scan_idx]),
      .scan_hold       (scan_hold),
      .scan_idx        (scan_idx),
      .mark_timed_out  (mark_timed_out),
      .err_timeout     (err_timeout),
      .err_timeout_tag (err_timeout_tag)
   );

   assign bus.err_dup         = err_dup_q;
   assign bus.err_dup_tag     = err_dup_tag_q;
   assign bus.err_unexp       = err_unexp_q;
   assign bus.err_unexp_tag   = err_unexp_tag_q;
   assign bus.err_timeout     = err_timeout;
   assign bus.err_timeout_tag = err_timeout_tag;
   assign bus.outstanding_cnt = cnt_q;

endmodule

// File: tb/tb_ccip_c0_tag_tracker.sv
// Scoreboard bench for ccip_c0_tag_tracker: directed scenarios plus random traffic on a few tags.
module tb_ccip_c0_tag_tracker;
   import ccip_tag_tracker_pkg::*;

   localparam int unsigned TW    = 6;
   localparam int          Depth = 64;
   localparam int          To    = 100;
   localparam int          Slack = To + Depth + 1;

   logic clk = 1'b0;
   logic SoftReset;
   always #5 clk = ~clk;

   ccip_c0_tag_tracker_if #(.TAG_WIDTH(TW)) bus ();

   ccip_c0_tag_tracker #(
      .TAG_WIDTH      (TW),
      .TS_WIDTH       (16),
      .TIMEOUT_CYCLES (To)
   ) dut (
      .clk       (clk),
      .SoftReset (SoftReset),
      .bus       (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int chk;
      bit rst;
      bit txv;
      int txtag;
      bit rxv;
      int rxtag;
      bit rsp_free;
      bit rsp_dec;
      bit dup;
      bit unexp;
      int cnt;
   } exp_t;

   exp_t exp_q[$];

   // Stimulus-side reference: which tags are outstanding and how many lines remain.
   bit m_busy[Depth];
   int m_rem[Depth];

   // Monitor-side timeout bookkeeping.
   bit t_busy[Depth];
   int t_issue[Depth];
   bit t_rep[Depth];
   bit t_chk[Depth];
   int t_late[Depth];

   task automatic drive(input bit rst, input bit txv, input int txtag, input int len,
                        input bit rxv, input int rxtag);
      exp_t e;
      @(posedge clk);
      #1;
      SoftReset        = rst;
      bus.c0tx_valid   = txv;
      bus.c0tx_mdata   = (16'($urandom) & ~16'(Depth - 1)) | 16'(txtag);
      bus.c0tx_cl_len  = 2'(len);
      bus.c0rx_rdvalid = rxv;
      bus.c0rx_mdata   = (16'($urandom) & ~16'(Depth - 1)) | 16'(rxtag);
      e.chk = cyc + 1;
      e.rst = rst;
      e.txv = txv;
      e.txtag = txtag;
      e.rxv = rxv;
      e.rxtag = rxtag;
      e.rsp_free = 1'b0;
      e.rsp_dec = 1'b0;
      e.dup = 1'b0;
      e.unexp = 1'b0;
      if (rst) begin
         for (int i = 0; i < Depth; i++) m_busy[i] = 1'b0;
      end else begin
         e.unexp    = rxv && !m_busy[rxtag];
         e.rsp_free = rxv && m_busy[rxtag] && (m_rem[rxtag] == 0);
         e.rsp_dec  = rxv && m_busy[rxtag] && (m_rem[rxtag] != 0);
         if (e.rsp_free) m_busy[rxtag] = 1'b0;
         if (e.rsp_dec) m_rem[rxtag] = m_rem[rxtag] - 1;
         e.dup = txv && m_busy[txtag];
         if (txv) begin
            m_busy[txtag] = 1'b1;
            m_rem[txtag]  = len;
         end
      end
      e.cnt = 0;
      for (int i = 0; i < Depth; i++) e.cnt += int'(m_busy[i]);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 0, 0, 1'b0, 0);
   endtask

   function automatic bit touched(exp_t e, int t);
      return !e.rst && ((e.txv && e.txtag == t) || (e.rxv && e.rxtag == t));
   endfunction

   initial begin : monitor
      exp_t e;
      int t;
      int age;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].chk < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL stale_record chk=%0d now=%0d", e.chk, cyc);
         end
         if (exp_q.size() > 0 && exp_q[0].chk == cyc) begin
            e = exp_q.pop_front();
            // Timeout pulse is judged against the table before this cycle's traffic.
            if (bus.err_timeout === 1'b1) begin
               t = int'(bus.err_timeout_tag);
               age = cyc - t_issue[t];
               checks++;
               if (e.rst || !t_busy[t] || t_rep[t] || touched(e, t) || age < To ||
                   age > Slack + Depth * t_late[t]) begin
                  errors++;
                  $display("FAIL timeout_pulse cyc=%0d tag=%0d age=%0d busy=%0b reported=%0b, required pending unreported untouched tag aged %0d..%0d",
                           cyc, t, age, t_busy[t], t_rep[t], To, Slack + Depth * t_late[t]);
               end
               t_rep[t] = 1'b1;
            end
            checks++;
            if (bus.err_dup !== e.dup || (e.dup && bus.err_dup_tag !== TW'(e.txtag))) begin
               errors++;
               $display("FAIL err_dup cyc=%0d got=%0b/%0d required=%0b/%0d",
                        cyc, bus.err_dup, bus.err_dup_tag, e.dup, e.txtag);
            end
            checks++;
            if (bus.err_unexp !== e.unexp ||
                (e.unexp && bus.err_unexp_tag !== TW'(e.rxtag))) begin
               errors++;
               $display("FAIL err_unexp cyc=%0d got=%0b/%0d required=%0b/%0d",
                        cyc, bus.err_unexp, bus.err_unexp_tag, e.unexp, e.rxtag);
            end
            checks++;
            if (bus.outstanding_cnt !== (TW + 1)'(e.cnt)) begin
               errors++;
               $display("FAIL outstanding_cnt cyc=%0d got=%0d required=%0d",
                        cyc, bus.outstanding_cnt, e.cnt);
            end
            if (e.rst) begin
               checks++;
               if (bus.err_timeout !== 1'b0 || bus.err_dup_tag !== '0 ||
                   bus.err_unexp_tag !== '0 || bus.err_timeout_tag !== '0) begin
                  errors++;
                  $display("FAIL reset_outputs cyc=%0d got to=%0b tags=%0d/%0d/%0d required all 0",
                           cyc, bus.err_timeout, bus.err_dup_tag, bus.err_unexp_tag,
                           bus.err_timeout_tag);
               end
               for (int i = 0; i < Depth; i++) begin
                  t_busy[i] = 1'b0;
                  t_rep[i]  = 1'b0;
                  t_chk[i]  = 1'b0;
                  t_late[i] = 0;
               end
            end else begin
               if (e.rsp_free) t_busy[e.rxtag] = 1'b0;
               else if (e.rsp_dec && cyc - t_issue[e.rxtag] >= To) t_late[e.rxtag]++;
               if (e.txv) begin
                  t_busy[e.txtag]  = 1'b1;
                  t_issue[e.txtag] = cyc;
                  t_rep[e.txtag]   = 1'b0;
                  t_chk[e.txtag]   = 1'b0;
                  t_late[e.txtag]  = 0;
               end
            end
         end
         for (int i = 0; i < Depth; i++) begin
            if (t_busy[i] && !t_chk[i] && cyc - t_issue[i] > Slack + Depth * t_late[i]) begin
               t_chk[i] = 1'b1;
               checks++;
               if (!t_rep[i]) begin
                  errors++;
                  $display("FAIL timeout_missing tag=%0d age=%0d got no pulse required one by age %0d",
                           i, cyc - t_issue[i], Slack + Depth * t_late[i]);
               end
            end
         end
      end
   end

   initial begin : stimulus
      SoftReset        = 1'b1;
      bus.c0tx_valid   = 1'b0;
      bus.c0tx_mdata   = '0;
      bus.c0tx_cl_len  = '0;
      bus.c0rx_rdvalid = 1'b0;
      bus.c0rx_mdata   = '0;

      drive(1'b1, 1'b1, 4, 1, 1'b1, 4);
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0);
      idle(2);
      // Response into an empty table.
      drive(1'b0, 1'b0, 0, 0, 1'b1, 9);
      idle(2);
      // Four-line read, four responses.
      drive(1'b0, 1'b1, 5, 3, 1'b0, 0);
      idle(8);
      repeat (4) drive(1'b0, 1'b0, 0, 0, 1'b1, 5);
      idle(2);
      // Duplicate request on tag 7.
      drive(1'b0, 1'b1, 7, 1, 1'b0, 0);
      idle(2);
      drive(1'b0, 1'b1, 7, 1, 1'b0, 0);
      idle(2);
      // Timeout on tag 3, then a late response.
      drive(1'b0, 1'b1, 3, 0, 1'b0, 0);
      idle(170);
      drive(1'b0, 1'b0, 0, 0, 1'b1, 3);
      idle(2);
      // Final response and re-request on tag 2 in the same cycle.
      drive(1'b0, 1'b1, 2, 0, 1'b0, 0);
      idle(2);
      drive(1'b0, 1'b1, 2, 1, 1'b1, 2);
      idle(2);
      // Reset with traffic in flight.
      drive(1'b0, 1'b1, 10, 2, 1'b0, 0);
      drive(1'b0, 1'b1, 11, 2, 1'b0, 0);
      drive(1'b0, 1'b1, 12, 2, 1'b1, 10);
      drive(1'b1, 1'b1, 13, 0, 1'b1, 11);
      drive(1'b0, 1'b0, 0, 0, 1'b1, 11);
      idle(2);

      repeat (3000) begin
         drive($urandom_range(0, 199) == 0, 1'($urandom), $urandom_range(0, 7),
               $urandom_range(0, 3), $urandom_range(0, 99) < 60, $urandom_range(0, 7));
      end
      idle(200);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending records required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ccip_c0_tag_tracker.md
Name: ccip_c0_tag_tracker

Overview:
- Passive CCI-P channel-0 read-transaction tracker. Sits directly upstream of the CCI-P protocol checker in the sniffer path.
- Observes C0 TX read requests and C0 RX read responses, keyed by mdata tag.
- Keeps a table of outstanding reads and raises per-cycle error pulses: duplicate tag, unexpected/excess response, timeout. The checker consumes and logs these pulses.
- Never drives or stalls the CCI-P bus.

Parameters:
- TAG_WIDTH, 6: tracked tag = mdata[TAG_WIDTH-1:0]; table depth is 2**TAG_WIDTH.
- TS_WIDTH, 16: free-running timestamp width; arithmetic wraps modulo 2**TS_WIDTH.
- TIMEOUT_CYCLES, 4096: request age at which a timeout is reported. Must be < 2**(TS_WIDTH-1); elaboration-time assertion.

Ports:
- clk  in  1  sole clock
- SoftReset  in  1  synchronous, active-high reset
- c0tx_valid  in  1  C0 read request issued this cycle
- c0tx_mdata  in  16  request mdata
- c0tx_cl_len  in  2  request length in lines minus 1 (0..3)
- c0rx_rdvalid  in  1  C0 read-response line this cycle
- c0rx_mdata  in  16  response mdata
- err_dup  out  1  pulse: request tag already outstanding
- err_dup_tag  out  TAG_WIDTH  tag for err_dup
- err_unexp  out  1  pulse: response to a FREE tag
- err_unexp_tag  out  TAG_WIDTH  tag for err_unexp
- err_timeout  out  1  pulse: outstanding request aged out
- err_timeout_tag  out  TAG_WIDTH  tag for err_timeout
- outstanding_cnt  out  TAG_WIDTH+1  number of non-FREE entries

Behaviour:
- Reset (synchronous, active-high, honoured in any state):
  - every entry returns to FREE;
  - timestamp, scan index and outstanding_cnt go to 0;
  - all err_* outputs and err_*_tag outputs go to 0.
  - Inputs sampled in the reset cycle are ignored.
- Entry fields: state {FREE, PENDING, TIMED_OUT}, remaining lines (2 bits), issue timestamp (TS_WIDTH).
- Outputs are registered. An error pulse appears exactly 1 cycle after the offending input cycle and lasts 1 cycle.
- Request, tag T:
  - if entry T is FREE: entry goes to PENDING, remaining = cl_len, timestamp = now.
  - otherwise: err_dup=1, err_dup_tag=T; the entry is overwritten with the new request (PENDING, new cl_len, new timestamp).
- Response, tag T:
  - if entry T is FREE: err_unexp=1, err_unexp_tag=T; table unchanged.
  - if PENDING or TIMED_OUT with remaining=0: entry goes to FREE, with no error (a late response to a TIMED_OUT entry is not an error).
  - otherwise: remaining decrements by 1; state is unchanged.
- Same-cycle request and response:
  - the response is evaluated against pre-cycle state first, then the request against the post-response state;
  - a final response freeing T plus a new request on T gives a clean re-allocation, no err_dup;
  - response and request to a FREE T gives err_unexp, and the request still allocates.
- Timeout scan:
  - one entry per cycle; the index increments and wraps from 2**TAG_WIDTH-1 to 0;
  - if the scanned entry is PENDING and (now - ts) mod 2**TS_WIDTH >= TIMEOUT_CYCLES: err_timeout=1, err_timeout_tag=index, entry goes to TIMED_OUT;
  - each request is reported at most once;
  - worst-case report latency is TIMEOUT_CYCLES + 2**TAG_WIDTH + 1 cycles;
  - if the scanner and a same-cycle response/request touch the same entry, the response/request update wins and the timeout is suppressed that cycle.
- outstanding_cnt:
  - +1 on FREE to non-FREE, -1 on non-FREE to FREE, net in the same cycle;
  - never exceeds 2**TAG_WIDTH.
- The three error classes are independent and may pulse in the same cycle.
- Only mdata[TAG_WIDTH-1:0] is compared; upper mdata bits are ignored.

Decomposition:
- Package ccip_tag_tracker_pkg holds:
  - enum tag_state_e (FREE/PENDING/TIMED_OUT);
  - struct tag_entry_t;
  - localparam default widths.
- One sub-module, ccip_tag_timeout_scanner, holds the scan index, the age compare and the timeout pulse register. It reads the entry it selects and returns a mark-TIMED_OUT strobe.
- The table update logic stays in the top module.

Test Plan:
- Request tag 5, cl_len=3; responses on tag 5 at cycles 10,11,12,13 -> no errors; outstanding_cnt 1 then 0 the cycle after the 4th response.
- Request tag 7 twice, 3 cycles apart, with no response between -> err_dup=1, err_dup_tag=7 one cycle after the second request; outstanding_cnt stays 1.
- Response on tag 9 with an empty table -> err_unexp=1, err_unexp_tag=9 one cycle later; outstanding_cnt=0.
- TIMEOUT_CYCLES=100, request tag 3, no response -> err_timeout with tag 3 between cycle 100 and 165 after issue, exactly once. A later response on tag 3 -> no error, outstanding_cnt 0.
- Tag 2 outstanding with cl_len=0, final response plus new request on tag 2 in the same cycle -> no err_dup, entry PENDING, outstanding_cnt stays 1.
- Three outstanding tags, assert SoftReset mid-burst -> outstanding_cnt=0 and all err_* outputs 0 the next cycle; a subsequent response on a previously issued tag -> err_unexp.
